key_input_pio: RTL and testbench
================================

// Module: key_input_pio
// PURPOSE
//  Avalon-MM slave input port: samples external push-buttons/switches, synchronises (and optionally
//  debounces) them, captures edges per bit and raises a maskable level interrupt to the Nios II.
//  Read-side counterpart of the output PIO driving the red LEDs; same s1 bus timing, zero wait states.
// PARAMETERS
//  WIDTH            4      number of input bits (1..32)
//  EDGE_TYPE        1      0 = rising, 1 = falling, 2 = any edge captured
//  DEBOUNCE_CYCLES  65536  consecutive stable clk cycles before a change is accepted (macro only)
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      register select (word offset)
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  in_port     in   WIDTH  raw asynchronous inputs (DE2 keys idle high)
//  readdata    out  32     read data, bits above WIDTH are 0
//  irq         out  1      level interrupt to CPU
// BEHAVIOUR
//  Register map: 0 DATA (RO, filtered level); 1 reserved (reads 0, writes ignored);
//   2 IRQMASK (RW, WIDTH bits); 3 EDGECAP (read; write-1-to-clear per bit).
//  Reset values: readdata=0, irq=0, IRQMASK=0, EDGECAP=0; sync/filtered/prev registers all-ones
//   (idle level) so no edge is captured on reset release with inputs idle.
//  Sync: 2-flop synchroniser per bit; filtered level = sync output (or debounced value).
//  Edge detect: prev <= filtered each cycle; rise=filtered&~prev, fall=~filtered&prev, per EDGE_TYPE.
//  EDGECAP bit sets the cycle after filtered changes; stays set until cleared.
//  Write to 3 with bit=1 clears that bit; same-cycle edge on that bit wins (bit stays 1).
//  Read latency 1: readdata registered on cycle with chipselect&write_n; holds value otherwise.
//  irq = |(EDGECAP & IRQMASK), combinational from flops; deasserts the cycle after clearing write.
//  Latency in_port -> DATA visible via readdata: 2 sync + 1 prev/readdata register cycles (no macro).
//  Writes with address 0/1 are ignored; writedata bits >= WIDTH ignored.
//  Reset mid-operation: all state returns to reset values immediately (async).
// CONFIGURATION
//  KEY_INPUT_PIO_DEBOUNCE_EN defined: per-bit counter; filtered bit toggles only after sync value
//   differs from filtered for DEBOUNCE_CYCLES consecutive cycles; any return to filtered value
//   resets the counter to 0. Counter width $clog2(DEBOUNCE_CYCLES+1), saturates, no wrap.
//  Not defined: filtered = synchroniser output, no counters synthesised, DEBOUNCE_CYCLES unused.
// STRUCTURE
//  Package key_input_pio_pkg: register offsets ADDR_DATA/ADDR_IRQMASK/ADDR_EDGECAP,
//   edge-type constants EDGE_RISE/EDGE_FALL/EDGE_ANY.
//  Sub-module key_sync_debounce (one bit: 2-flop sync + optional debounce counter), generated
//   WIDTH times; top holds edge detect, registers, read mux, irq.
// TESTING  (WIDTH=4, EDGE_TYPE=1; DEBOUNCE_CYCLES=8 when macro defined)
//  Reset with in_port=4'hF -> readdata=0, irq=0; read addr 0 -> 32'h0000000F, addr 3 -> 0.
//  in_port 4'hF->4'hE held -> EDGECAP=4'h1 after 3 clk; with IRQMASK=0 irq stays 0; write
//   IRQMASK=4'h1 -> irq=1 next cycle.
//  Write addr 3 data 4'h1 -> EDGECAP=0, irq=0 next cycle; simultaneous new falling edge bit0
//   with clear -> EDGECAP bit0 remains 1.
//  in_port bit2 falls, rises -> only falling captured (EDGECAP=4'h4); EDGE_TYPE=2 build -> both.
//  Macro on: 5-cycle glitch on bit1 -> DATA unchanged, EDGECAP=0; 8+ cycle low -> bit1 captured.
//  Assert reset_n mid-count/with EDGECAP=4'hF -> all registers, irq return to reset values at once.

Source files
------------

// File: rtl/key_input_pio_pkg.sv
// Shared constants for the push-button/switch input PIO: register offsets,
// edge-capture modes and the debounce counter sizing helper.
package key_input_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int BUS_WIDTH = 32;

    // Enough bits to hold a count of 0..cycles without wrapping.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// One input bit: two-flop synchroniser, optionally followed by a debounce filter.
// The filter is built only when KEY_INPUT_PIO_DEBOUNCE_EN is defined.
module key_sync_debounce
    import key_input_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic filtered
);

    logic sync_meta;
    logic sync_out;

    // Both stages reset to the idle (released) key level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
    localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt;
    logic             filt_q;

    // Count consecutive cycles the synchronised value disagrees with the
    // accepted level; any agreement restarts the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_cnt <= '0;
            filt_q     <= 1'b1;
        end else if (sync_out == filt_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt >= CNT_LAST) begin
            filt_q     <= sync_out;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign filtered = filt_q;
`else
    assign filtered = sync_out;
`endif

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("key_sync_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

endmodule

// File: rtl/key_input_pio.sv
// Avalon-MM input PIO for push-buttons/switches: synchronise (optionally debounce,
// see KEY_INPUT_PIO_DEBOUNCE_EN), capture edges per bit and raise a maskable level irq.
module key_input_pio
    import key_input_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = EDGE_FALL,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    input  logic [WIDTH-1:0]     in_port,
    output logic [31:0]          readdata,
    output logic                 irq
);

    // Bus semantics: no handshake and zero wait states. A cycle with chipselect
    // high is a transfer; write_n low makes it a write that takes effect at the
    // clock edge, write_n high makes it a read whose data appears on readdata the
    // cycle after and then holds until the next read.
    logic bus_read;
    logic bus_write;

    assign bus_read  = chipselect &  write_n;
    assign bus_write = chipselect & ~write_n;

    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] wr_bits;
    logic [31:0]      read_word;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        key_sync_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sync (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw      (in_port[i]),
            .filtered (filtered[i])
        );
    end

    assign wr_bits = writedata[WIDTH-1:0];

    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_evt = filtered & ~prev;
            EDGE_FALL: edge_evt = ~filtered & prev;
            default:   edge_evt = (filtered & ~prev) | (~filtered & prev);
        endcase
    end

    // A fresh edge is OR-ed in after the clear, so it survives a same-cycle clear.
    always_comb begin
        edge_clr = '0;
        if (bus_write && address == ADDR_EDGECAP) begin
            edge_clr = wr_bits;
        end
        edge_cap_next = (edge_cap & ~edge_clr) | edge_evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '1;
            edge_cap <= '0;
            irq_mask <= '0;
        end else begin
            prev     <= filtered;
            edge_cap <= edge_cap_next;
            if (bus_write && address == ADDR_IRQMASK) begin
                irq_mask <= wr_bits;
            end
        end
    end

    always_comb begin
        read_word = '0;
        case (address)
            ADDR_DATA:    read_word[WIDTH-1:0] = filtered;
            ADDR_IRQMASK: read_word[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: read_word[WIDTH-1:0] = edge_cap;
            default:      read_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (bus_read) begin
            readdata <= read_word;
        end
    end

    assign irq = |(edge_cap & irq_mask);

    if (WIDTH < BUS_WIDTH) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[31:(WIDTH < BUS_WIDTH ? WIDTH : 0)];
    end

    if (WIDTH < 1 || WIDTH > BUS_WIDTH) begin : g_bad_width
        $error("key_input_pio: WIDTH must be in 1..32");
    end
    if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
        $error("key_input_pio: EDGE_TYPE must be 0, 1 or 2");
    end

endmodule

// File: tb/tb_key_input_pio.sv
// Self-checking bench for key_input_pio: directed steps plus random traffic,
// checked every cycle against a delay-line / edge-rule reference model.
module tb_key_input_pio;

    localparam int TB_EDGE_TYPE = 1;
    localparam int DB           = 8;
`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
    localparam int EVT_TICKS = 3 + DB;
`else
    localparam int EVT_TICKS = 3;
`endif
    localparam int HOLD = 14;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp;
    int n_fail;

    key_input_pio #(
        .WIDTH           (4),
        .EDGE_TYPE       (TB_EDGE_TYPE),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: two-sample delay line, accepted level, previous level.
    logic [3:0]  m_s1, m_s2, m_filt, m_prev, m_cap, m_mask;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [3:0]  hist[$];

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_filt = 4'hF; m_prev = 4'hF;
        m_cap = 4'h0; m_mask = 4'h0; m_rd = 32'h0; m_irq = 1'b0;
        hist.delete();
    endtask

    task automatic model_step(input logic cs, input logic wn, input logic [1:0] a,
                              input logic [31:0] wd, input logic [3:0] inp);
        logic [3:0] nf, evt, clr;
        logic       all_diff;
`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
        // A bit is accepted once the last DB synchronised samples all disagree with it.
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        nf = m_filt;
        for (int b = 0; b < 4; b++) begin
            all_diff = (hist.size() == DB);
            foreach (hist[j]) if (hist[j][b] == m_filt[b]) all_diff = 1'b0;
            if (all_diff) nf[b] = ~m_filt[b];
        end
`else
        all_diff = 1'b0;
        nf = m_s1;
`endif
        case (TB_EDGE_TYPE)
            0:       evt = m_filt & ~m_prev;
            1:       evt = ~m_filt & m_prev;
            default: evt = m_filt ^ m_prev;
        endcase
        clr = (cs && !wn && a == 2'd3) ? wd[3:0] : 4'h0;
        if (cs && wn) begin
            case (a)
                2'd0:    m_rd = {28'h0, m_filt};
                2'd2:    m_rd = {28'h0, m_mask};
                2'd3:    m_rd = {28'h0, m_cap};
                default: m_rd = 32'h0;
            endcase
        end
        if (cs && !wn && a == 2'd2) m_mask = wd[3:0];
        m_cap  = (m_cap & ~clr) | evt;
        m_prev = m_filt;
        m_filt = nf;
        m_s2   = m_s1;
        m_s1   = inp;
        m_irq  = |(m_cap & m_mask);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        @(posedge clk);
        model_step(cs, wn, a, wd, in_port);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        check("readdata", readdata, m_rd);
        check("irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
        tick(1'b1, 1'b1, a, $urandom);
        check(tag, readdata, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0; in_port = 4'hF;
        model_reset();
        do_reset();

        // Idle after reset
        rd_expect("data_idle", 2'd0, 32'h0000000F);
        rd_expect("edgecap_idle", 2'd3, 32'h0);
        rd_expect("reserved", 2'd1, 32'h0);

        // Falling edge on bit0, masked then unmasked
        in_port = 4'hE;
`ifndef KEY_INPUT_PIO_DEBOUNCE_EN
        tick(1'b1, 1'b1, 2'd3, 32'h0);
        tick(1'b1, 1'b1, 2'd3, 32'h0);
        tick(1'b1, 1'b1, 2'd3, 32'h0);
        check("edgecap_before_3clk", readdata, 32'h0);
        tick(1'b1, 1'b1, 2'd3, 32'h0);
        check("edgecap_at_3clk", readdata, 32'h1);
`else
        idle(HOLD);
`endif
        rd_expect("edgecap_bit0", 2'd3, 32'h1);
        check("irq_masked", {31'h0, irq}, 32'h0);
        wr(2'd2, 32'h1);
        check("irq_unmasked", {31'h0, irq}, 32'h1);

        // Clear, then clear colliding with a fresh edge
        wr(2'd3, 32'h1);
        check("irq_cleared", {31'h0, irq}, 32'h0);
        rd_expect("edgecap_cleared", 2'd3, 32'h0);
        in_port = 4'hF;
        idle(HOLD);
        rd_expect("rise_ignored", 2'd3, 32'h0);
        in_port = 4'hE;
        idle(EVT_TICKS - 1);
        wr(2'd3, 32'h1);
        check("irq_clear_collide", {31'h0, irq}, 32'h1);
        rd_expect("edgecap_clear_collide", 2'd3, 32'h1);

        // bit2 falls then rises: only the fall is captured
        wr(2'd3, 32'hF);
        in_port = 4'hA;
        idle(HOLD);
        in_port = 4'hE;
        idle(HOLD);
        rd_expect("edgecap_bit2_fall", 2'd3, 32'h4);
        check("irq_bit2_unmasked_off", {31'h0, irq}, 32'h0);

        // Ignored writes and truncated writedata
        wr(2'd0, 32'h0);
        wr(2'd1, 32'hFFFFFFFF);
        rd_expect("data_after_wr0", 2'd0, 32'hE);
        rd_expect("mask_after_wr1", 2'd2, 32'h1);
        wr(2'd2, 32'hFFFFFFF0);
        rd_expect("mask_hi_bits", 2'd2, 32'h0);
        wr(2'd2, 32'hFFFFFFFF);
        rd_expect("mask_all", 2'd2, 32'hF);
        check("irq_bit2_masked_on", {31'h0, irq}, 32'h1);

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
        // Short glitch on bit1 is rejected, a long low is accepted
        wr(2'd3, 32'hF);
        in_port = 4'hC;
        idle(5);
        in_port = 4'hE;
        idle(HOLD);
        rd_expect("glitch_data", 2'd0, 32'hE);
        rd_expect("glitch_edgecap", 2'd3, 32'h0);
        in_port = 4'hC;
        idle(HOLD);
        rd_expect("long_low_edgecap", 2'd3, 32'h2);
        rd_expect("long_low_data", 2'd0, 32'hC);
`endif

        // All bits captured, then reset while a change is in flight
        in_port = 4'hF;
        idle(HOLD);
        wr(2'd3, 32'hF);
        in_port = 4'h0;
        idle(HOLD);
        rd_expect("edgecap_all", 2'd3, 32'hF);
        in_port = 4'hF;
        idle(3);
        do_reset();
        rd_expect("mask_after_reset", 2'd2, 32'h0);
        rd_expect("edgecap_after_reset", 2'd3, 32'h0);
        rd_expect("data_after_reset", 2'd0, 32'hF);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            int op;
            if ($urandom_range(0, 9) == 0) in_port[$urandom_range(0, 3)] ^= 1'b1;
            op = $urandom_range(0, 9);
            if (op < 6)      tick(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
            else if (op < 8) tick(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
            else             idle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
